output_port_arbiter: RTL

//  Per-output-port round-robin arbiter for the NoC router. Collects the one-bit port

---
 rtl/output_port_arbiter_if.sv | 39 +++
 rtl/output_port_arbiter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/output_port_arbiter_if.sv
// Handshake bundle between one output-port arbiter and the five input ports it serves.
// master = input-port / downstream side, slave = arbiter.
`ifndef HEADER
`define HEADER  3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL    3'b100
`endif

interface output_port_arbiter_if #(
    parameter int N_IN    = 5,
    parameter int CREDITS = 4
);
    localparam int CW = $clog2(CREDITS + 1);

    logic [N_IN-1:0]   req;
    logic [N_IN-1:0]   valid_in;
    logic [3*N_IN-1:0] flit_id_in;
    logic              credit_in;
    logic [N_IN-1:0]   grant;
    logic [2:0]        xbar_sel;
    logic [N_IN-1:0]   rd_en;
    logic              flit_go;
    logic [CW-1:0]     credit_cnt;
    logic              credit_err;

    modport master (
        output req, valid_in, flit_id_in, credit_in,
        input  grant, xbar_sel, rd_en, flit_go, credit_cnt, credit_err
    );

    modport slave (
        input  req, valid_in, flit_id_in, credit_in,
        output grant, xbar_sel, rd_en, flit_go, credit_cnt, credit_err
    );
endinterface

// File: rtl/output_port_arbiter.sv
// Round-robin wormhole arbiter for one router output port: locks the output to an input
// from HEADER to TAIL and gates every flit on the downstream credit count.
`ifndef HEADER
`define HEADER  3'b001
`endif
`ifndef TAIL
`define TAIL    3'b100
`endif

module output_port_arbiter #(
    parameter int N_IN    = 5,
    parameter int CREDITS = 4
) (
    input logic                   clk,
    input logic                   rst,
    output_port_arbiter_if.slave  arb
);
    localparam int CW = $clog2(CREDITS + 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state, state_nxt;
    logic [N_IN-1:0] grant_q, grant_nxt;
    logic [2:0]      sel_q, sel_nxt;
    logic [2:0]      ptr_q, ptr_nxt;
    logic [CW-1:0]   cnt_q, cnt_nxt;
    logic            err_q, err_nxt;

    logic [N_IN-1:0] eligible;
    logic            found;
    logic [2:0]      winner;
    logic            xfer;
    logic            owner_tail;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= CW'(CREDITS);
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            grant_q <= grant_nxt;
            sel_q   <= sel_nxt;
            ptr_q   <= ptr_nxt;
            cnt_q   <= cnt_nxt;
            err_q   <= err_nxt;
        end
    end

    // Search starts at the pointer, so the input that released last ranks lowest.
    always_comb begin : rr_search
        int unsigned idx;
        eligible = '0;
        found    = 1'b0;
        winner   = '0;
        idx      = 0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            eligible[i] = arb.req[i] & arb.valid_in[i]
                        & (arb.flit_id_in[3*i +: 3] == `HEADER);
        end
        for (int unsigned k = 0; k < N_IN; k++) begin
            idx = (int'(ptr_q) + k) % N_IN;
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = 3'(idx);
            end
        end
    end

    always_comb begin
        xfer       = (state == LOCKED) & arb.valid_in[sel_q] & (cnt_q != '0);
        owner_tail = (arb.flit_id_in[3*int'(sel_q) +: 3] == `TAIL);
    end

    always_comb begin : next_state
        state_nxt = state;
        grant_nxt = grant_q;
        sel_nxt   = sel_q;
        ptr_nxt   = ptr_q;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = LOCKED;
                    grant_nxt = N_IN'(1) << winner;
                    sel_nxt   = winner;
                end
            end
            LOCKED: begin
                if (xfer && owner_tail) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    sel_nxt   = '0;
                    ptr_nxt   = (sel_q == 3'(N_IN - 1)) ? 3'd0 : sel_q + 3'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Simultaneous pop and returned credit cancel out; overflow only flags, never wraps.
    always_comb begin : credit_next
        cnt_nxt = cnt_q;
        err_nxt = err_q;
        if (xfer && !arb.credit_in) begin
            cnt_nxt = cnt_q - CW'(1);
        end else if (!xfer && arb.credit_in) begin
            if (cnt_q == CW'(CREDITS)) err_nxt = 1'b1;
            else                       cnt_nxt = cnt_q + CW'(1);
        end
    end

    always_comb begin : outputs
        arb.rd_en = '0;
        if (xfer) arb.rd_en[sel_q] = 1'b1;
        arb.flit_go    = xfer;
        arb.grant      = grant_q;
        arb.xbar_sel   = sel_q;
        arb.credit_cnt = cnt_q;
        arb.credit_err = err_q;
    end
endmodule
